// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver: oversampled rx line to byte strobe with framing-error pulse
module uart_rx_byte #(
    parameter int BAUD_DIV = 434,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(BAUD_DIV);
    // The counter is loaded with N-1 and expires at zero so BAUD_DIV fits even when it is a power of two.
    localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          prev_q;
    state_t        state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          rdy_q;
    logic          ferr_q;
    logic          busy_q;
    logic          start_edge;
    logic          baud_done;
    logic [CW-1:0] baud_dec;

    assign start_edge = prev_q & ~sync2_q;
    assign baud_done  = (baud_q == '0);
    assign baud_dec   = baud_q - CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rdy_q  <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_q <= S_START;
                        baud_q  <= HALF_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (!baud_done) begin
                        baud_q <= baud_dec;
                    end else if (sync2_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_DATA;
                        baud_q  <= BAUD_LOAD;
                        bit_q   <= '0;
                    end
                end
                S_DATA: begin
                    if (!baud_done) begin
                        baud_q <= baud_dec;
                    end else begin
                        shift_q <= {sync2_q, shift_q[7:1]};
                        baud_q  <= BAUD_LOAD;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (!baud_done) begin
                        baud_q <= baud_dec;
                    end else begin
                        // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                        if (sync2_q) begin
                            data_q <= shift_q;
                            rdy_q  <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_rdy    = rdy_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule
